// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefDataW = 32;
  localparam int unsigned NumReq   = 2;

  // One-hot grant encoding, bit 0 = fetch, bit 1 = data.
  localparam logic [NumReq-1:0] GntNone = 2'b00;
  localparam logic [NumReq-1:0] GntIf   = 2'b01;
  localparam logic [NumReq-1:0] GntD    = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD,
    StResp
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; suffixes are from the arbiter's view.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
);

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_data_o;
  logic              if_ack_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_ack_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ready_i;

  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i, mem_ready_i,
    output if_data_o, if_ack_o, d_rdata_o, d_ack_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i, mem_ready_i,
    input  if_data_o, if_ack_o, d_rdata_o, d_ack_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle counter; timeout_o pulses on the last allowed busy cycle.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = en_i & (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between fetch and load/store requesters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  mem_port_arbiter_if.slave        bus_io,
  output logic                     stall_o,
  output logic                     err_o
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  state_e              state_q, state_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_data_q, if_data_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_ack_q, if_ack_d;
  logic                d_ack_q, d_ack_d;
  logic                err_q, err_d;
  logic [NumReq-1:0]   gnt;
  logic                busy, wd_timeout;

  assign busy = (state_q == StBusyI) || (state_q == StBusyD);

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_q == StResp),
    .en_i     (busy),
    .timeout_o(wd_timeout)
  );

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_data_d   = if_data_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = err_q;
    gnt         = GntNone;

    unique case (state_q)
      StIdle: begin
        // Data wins unless a waiting fetch has already been passed over STARVE_MAX times.
        if (bus_io.d_req_i && (!bus_io.if_req_i || (starve_q < StarveW'(STARVE_MAX)))) begin
          gnt = GntD;
        end else if (bus_io.if_req_i) begin
          gnt = GntIf;
        end

        unique case (gnt)
          GntD: begin
            state_d     = StBusyD;
            mem_req_d   = 1'b1;
            mem_we_d    = bus_io.d_we_i;
            mem_addr_d  = bus_io.d_addr_i;
            mem_wdata_d = bus_io.d_wdata_i;
            if (bus_io.if_req_i && (starve_q < StarveW'(STARVE_MAX))) begin
              starve_d = starve_q + StarveW'(1);
            end
          end
          GntIf: begin
            state_d     = StBusyI;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus_io.if_addr_i;
            mem_wdata_d = '0;
            starve_d    = '0;
          end
          default: ;
        endcase
      end

      StBusyI, StBusyD: begin
        if (bus_io.mem_ready_i || wd_timeout) begin
          state_d   = StResp;
          mem_req_d = 1'b0;
          if (!bus_io.mem_ready_i) begin
            err_d = 1'b1;
          end
          if (state_q == StBusyI) begin
            if_ack_d  = 1'b1;
            if_data_d = bus_io.mem_ready_i ? bus_io.mem_rdata_i : '0;
          end else begin
            d_ack_d = 1'b1;
            if (!bus_io.mem_ready_i) begin
              d_rdata_d = '0;
            end else if (!mem_we_q) begin
              d_rdata_d = bus_io.mem_rdata_i;
            end
          end
        end
      end

      StResp: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_data_q   <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_data_q   <= if_data_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
    end
  end

  assign bus_io.mem_req_o   = mem_req_q;
  assign bus_io.mem_we_o    = mem_we_q;
  assign bus_io.mem_addr_o  = mem_addr_q;
  assign bus_io.mem_wdata_o = mem_wdata_q;
  assign bus_io.if_data_o   = if_data_q;
  assign bus_io.d_rdata_o   = d_rdata_q;
  assign bus_io.if_ack_o    = if_ack_q;
  assign bus_io.d_ack_o     = d_ack_q;
  assign err_o              = err_q;

  assign stall_o = (bus_io.if_req_i & ~if_ack_q) | (bus_io.d_req_i & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: requester tasks queue expected acks, a memory model checks issued requests.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          start;
    logic        err;
  } ack_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;   // busy cycle that sees ready; 0 = never
  } mem_t;

  logic clk_i = 1'b0;
  logic rst_i;
  logic stall_o, err_o;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   tie_ready = 1'b0;

  ack_t exp_if[$];
  ack_t exp_d[$];
  mem_t mem_q[$];

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(4),
    .TIMEOUT   (64)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bus_io (bus),
    .stall_o(stall_o),
    .err_o  (err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event did not match expectation (cycle %0d)", name, cyc);
  endtask

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int lat);
    mem_t m;
    m.we = we; m.addr = addr; m.wdata = wdata; m.rdata = rdata; m.lat = lat;
    mem_q.push_back(m);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the ack.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data, input int lat,
                       input logic exp_err, input bit chk_stall);
    ack_t e;
    int   n;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = addr;
    e.data = exp_data; e.lat = lat; e.start = cyc; e.err = exp_err;
    exp_if.push_back(e);
    n = 0;
    forever begin
      @(negedge clk_i);
      if (bus.if_ack_o) break;
      if (chk_stall) chk1("if_stall_wait", stall_o, 1'b1);
      n++;
      if (n > 300) begin
        fail_now("if_ack_timeout");
        break;
      end
    end
    if (chk_stall) chk1("if_stall_at_ack", stall_o, 1'b0);
    @(posedge clk_i);
    #1;
    bus.if_req_i = 1'b0;
  endtask

  task automatic data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input int lat, input logic exp_err);
    ack_t e;
    int   n;
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = we;
    bus.d_addr_i  = addr;
    bus.d_wdata_i = wdata;
    e.data = exp_rdata; e.lat = lat; e.start = cyc; e.err = exp_err;
    exp_d.push_back(e);
    n = 0;
    forever begin
      @(negedge clk_i);
      if (bus.d_ack_o) break;
      n++;
      if (n > 300) begin
        fail_now("d_ack_timeout");
        break;
      end
    end
    @(posedge clk_i);
    #1;
    bus.d_req_i = 1'b0;
  endtask

  // Ack monitor
  initial begin
    ack_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (bus.if_ack_o || bus.d_ack_o) chk1("ack_exclusive", bus.if_ack_o & bus.d_ack_o, 1'b0);
        if (bus.if_ack_o) begin
          if (exp_if.size() == 0) begin
            fail_now("if_ack_unexpected");
          end else begin
            e = exp_if.pop_front();
            chk("if_data", bus.if_data_o, e.data);
            chk("if_latency", cyc - e.start, e.lat);
            chk1("if_err", err_o, e.err);
          end
        end
        if (bus.d_ack_o) begin
          if (exp_d.size() == 0) begin
            fail_now("d_ack_unexpected");
          end else begin
            e = exp_d.pop_front();
            chk("d_rdata", bus.d_rdata_o, e.data);
            chk("d_latency", cyc - e.start, e.lat);
            chk1("d_err", err_o, e.err);
          end
        end
      end
    end
  end

  // Memory model: checks each issued request and answers after its scripted latency.
  initial begin
    mem_t cur;
    int   beat;
    bit   active;
    active = 1'b0;
    beat   = 0;
    cur    = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, rdata: 32'h0, lat: 0};
    forever begin
      @(negedge clk_i);
      if (rst_i || !bus.mem_req_o) begin
        active = 1'b0;
        bus.mem_ready_i = tie_ready;
      end else begin
        if (!active) begin
          if (mem_q.size() == 0) begin
            fail_now("mem_req_unexpected");
            cur = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, rdata: 32'h0, lat: 1};
          end else begin
            cur = mem_q.pop_front();
            chk1("mem_we", bus.mem_we_o, cur.we);
            chk("mem_addr", bus.mem_addr_o, cur.addr);
            if (cur.we) chk("mem_wdata", bus.mem_wdata_o, cur.wdata);
          end
          active = 1'b1;
          beat   = 1;
        end else begin
          beat++;
        end
        bus.mem_rdata_i = cur.rdata;
        bus.mem_ready_i = tie_ready || ((cur.lat != 0) && (beat == cur.lat));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_i = 1'b1;
    bus.if_req_i = 1'b0; bus.if_addr_i = '0;
    bus.d_req_i = 1'b0; bus.d_we_i = 1'b0; bus.d_addr_i = '0; bus.d_wdata_i = '0;
    bus.mem_rdata_i = '0; bus.mem_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk1("rst_if_ack", bus.if_ack_o, 1'b0);
    chk1("rst_d_ack", bus.d_ack_o, 1'b0);
    chk1("rst_mem_req", bus.mem_req_o, 1'b0);
    chk1("rst_mem_we", bus.mem_we_o, 1'b0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
    chk("rst_if_data", bus.if_data_o, 32'h0);
    chk("rst_d_rdata", bus.d_rdata_o, 32'h0);
    chk1("rst_err", err_o, 1'b0);
    chk1("rst_stall", stall_o, 1'b0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Fetch only: ready on 3rd busy cycle, ack at cycle 4
    push_mem(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3);
    fetch(32'h10, 32'hDEADBEEF, 4, 1'b0, 1'b1);

    // Starvation: four data grants, then the waiting fetch, then the last data request
    push_mem(1'b0, 32'h100, 32'h0, 32'h000000A0, 1);
    push_mem(1'b0, 32'h104, 32'h0, 32'h000000A1, 1);
    push_mem(1'b0, 32'h108, 32'h0, 32'h000000A2, 1);
    push_mem(1'b0, 32'h10C, 32'h0, 32'h000000A3, 1);
    push_mem(1'b0, 32'h40, 32'h0, 32'h11112222, 1);
    push_mem(1'b0, 32'h110, 32'h0, 32'h000000A4, 1);
    fork
      fetch(32'h40, 32'h11112222, 14, 1'b0, 1'b0);
      begin
        data(1'b0, 32'h100, 32'h0, 32'h000000A0, 2, 1'b0);
        data(1'b0, 32'h104, 32'h0, 32'h000000A1, 2, 1'b0);
        data(1'b0, 32'h108, 32'h0, 32'h000000A2, 2, 1'b0);
        data(1'b0, 32'h10C, 32'h0, 32'h000000A3, 2, 1'b0);
        data(1'b0, 32'h110, 32'h0, 32'h000000A4, 5, 1'b0);
      end
    join

    // Simultaneous: store first (starve counter back at 0), fetch after RESP
    push_mem(1'b1, 32'h20, 32'h55, 32'h0, 1);
    push_mem(1'b0, 32'h30, 32'h0, 32'hCAFEF00D, 2);
    fork
      fetch(32'h30, 32'hCAFEF00D, 6, 1'b0, 1'b1);
      data(1'b1, 32'h20, 32'h55, 32'h000000A4, 2, 1'b0);
    join

    // Zero-wait memory, back-to-back fetches
    tie_ready = 1'b1;
    bus.mem_ready_i = 1'b1;
    push_mem(1'b0, 32'h200, 32'h0, 32'h00000001, 1);
    push_mem(1'b0, 32'h204, 32'h0, 32'h00000002, 1);
    push_mem(1'b0, 32'h208, 32'h0, 32'h00000003, 1);
    fetch(32'h200, 32'h00000001, 2, 1'b0, 1'b0);
    fetch(32'h204, 32'h00000002, 2, 1'b0, 1'b0);
    fetch(32'h208, 32'h00000003, 2, 1'b0, 1'b0);
    tie_ready = 1'b0;
    bus.mem_ready_i = 1'b0;

    // Timeout on a load, then a store that succeeds with err still set
    push_mem(1'b0, 32'h300, 32'h0, 32'h12345678, 0);
    data(1'b0, 32'h300, 32'h0, 32'h0, 65, 1'b1);
    push_mem(1'b1, 32'h304, 32'h77, 32'h0, 2);
    data(1'b1, 32'h304, 32'h77, 32'h0, 3, 1'b1);
    @(negedge clk_i);
    chk1("err_sticky", err_o, 1'b1);

    // Reset during BUSY_D
    @(posedge clk_i);
    #1;
    push_mem(1'b0, 32'h400, 32'h0, 32'h0, 0);
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h400; bus.d_wdata_i = 32'h0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    bus.d_req_i = 1'b0;
    @(negedge clk_i);
    chk1("midrst_mem_req", bus.mem_req_o, 1'b0);
    chk1("midrst_err", err_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk1("midrst_no_d_ack", bus.d_ack_o, 1'b0);
      @(negedge clk_i);
    end
    @(posedge clk_i);
    #1;
    push_mem(1'b0, 32'h500, 32'h0, 32'h600D600D, 2);
    fetch(32'h500, 32'h600D600D, 3, 1'b0, 1'b0);

    repeat (3) @(negedge clk_i);
    chk("exp_if_drained", exp_if.size(), 32'd0);
    chk("exp_d_drained", exp_d.size(), 32'd0);
    chk("mem_q_drained", mem_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
